// File: rtl/quadrature_decoder_v2_if.sv
// Encoder pins, control strobes and decoded results for quadrature_decoder_v2.
// master drives pins/controls and observes results; slave is the decoder.
`timescale 1ns/1ps
interface quadrature_decoder_v2_if #(
    parameter int POS_W = 16,
    parameter int VEL_W = 16
);
    logic             enc_a;
    logic             enc_b;
    logic             enc_z;
    logic             clr_pos;
    logic             index_clr_en;
    logic             err_clr;
    logic [POS_W-1:0] pos;
    logic             dir;
    logic             step_valid;
    logic             index_pulse;
    logic [VEL_W-1:0] vel;
    logic             vel_valid;
    logic             err_illegal;

    modport master (
        output enc_a, enc_b, enc_z, clr_pos, index_clr_en, err_clr,
        input  pos, dir, step_valid, index_pulse, vel, vel_valid, err_illegal
    );
    modport slave (
        input  enc_a, enc_b, enc_z, clr_pos, index_clr_en, err_clr,
        output pos, dir, step_valid, index_pulse, vel, vel_valid, err_illegal
    );
endinterface

// File: rtl/quadrature_decoder_v2.sv
// x4 quadrature decoder: per-pin sync + glitch filter, signed position with
// index re-homing, illegal-transition flag and windowed velocity.
`timescale 1ns/1ps
module qd_input_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic filt_o
);
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [1:0]    sync_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter tracks how long sync has disagreed with the accepted level.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILT_LEN - 1))
                filt_d = sync_q[1];
            else
                cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;
endmodule

module quadrature_decoder_v2 #(
    parameter int POS_W      = 16,
    parameter int VEL_W      = 16,
    parameter int FILT_LEN   = 3,
    parameter int VEL_WINDOW = 12000,
    parameter int DIR_INVERT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    quadrature_decoder_v2_if.slave bus
);
    localparam int NUM_IN = 3;
    localparam int WIN_W  = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;

    logic [NUM_IN-1:0] pin_raw, filt;

    assign pin_raw = {bus.enc_z, bus.enc_b, bus.enc_a};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        qd_input_filter #(.FILT_LEN(FILT_LEN)) u_filt (
            .clk   (clk),
            .rst_n (rst_n),
            .pin_i (pin_raw[i]),
            .filt_o(filt[i])
        );
    end

    logic [1:0]       ab_prev_q;
    logic             z_prev_q;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             step_valid_q, index_pulse_q;
    logic [VEL_W-1:0] vel_q, vel_d;
    logic             vel_valid_q;
    logic             err_q, err_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [VEL_W-1:0] acc_q, acc_d;

    // Gray {A,B} mapped to a 2-bit phase: the phase difference is +1 forward,
    // -1 reverse and 2 when both bits flipped.
    logic [1:0] cur_ph, prev_ph, ph_delta;
    logic       step, illegal, fwd, idx_rise, win_last;
    logic [VEL_W:0]   acc_sum, step_ext;
    logic [VEL_W-1:0] acc_sat;

    assign cur_ph   = {filt[0], filt[0] ^ filt[1]};
    assign prev_ph  = {ab_prev_q[1], ab_prev_q[1] ^ ab_prev_q[0]};
    assign ph_delta = cur_ph - prev_ph;
    assign step     = ph_delta[0];
    assign illegal  = (ph_delta == 2'd2);
    assign fwd      = (ph_delta == 2'd1) ^ (DIR_INVERT != 0);
    assign idx_rise = filt[2] & ~z_prev_q;
    assign win_last = (win_q == WIN_W'(VEL_WINDOW - 1));

    always_comb begin
        step_ext = '0;
        if (step)
            step_ext = fwd ? (VEL_W+1)'(1) : '1;
        acc_sum = {acc_q[VEL_W-1], acc_q} + step_ext;
        if (acc_sum[VEL_W] != acc_sum[VEL_W-1])
            acc_sat = acc_sum[VEL_W] ? {1'b1, {(VEL_W-1){1'b0}}} : {1'b0, {(VEL_W-1){1'b1}}};
        else
            acc_sat = acc_sum[VEL_W-1:0];
    end

    always_comb begin
        pos_d = pos_q;
        if (bus.clr_pos)
            pos_d = '0;
        else if (idx_rise && bus.index_clr_en)
            pos_d = '0;
        else if (step)
            pos_d = fwd ? pos_q + POS_W'(1) : pos_q - POS_W'(1);

        dir_d = step ? fwd : dir_q;
        // Set beats clear so a coincident illegal transition is never lost.
        err_d = illegal | (err_q & ~bus.err_clr);

        win_d = win_last ? '0 : win_q + WIN_W'(1);
        acc_d = win_last ? '0 : acc_sat;
        vel_d = win_last ? acc_sat : vel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_prev_q     <= '0;
            z_prev_q      <= 1'b0;
            pos_q         <= '0;
            dir_q         <= 1'b0;
            step_valid_q  <= 1'b0;
            index_pulse_q <= 1'b0;
            vel_q         <= '0;
            vel_valid_q   <= 1'b0;
            err_q         <= 1'b0;
            win_q         <= '0;
            acc_q         <= '0;
        end else begin
            ab_prev_q     <= {filt[0], filt[1]};
            z_prev_q      <= filt[2];
            pos_q         <= pos_d;
            dir_q         <= dir_d;
            step_valid_q  <= step;
            index_pulse_q <= idx_rise;
            vel_q         <= vel_d;
            vel_valid_q   <= win_last;
            err_q         <= err_d;
            win_q         <= win_d;
            acc_q         <= acc_d;
        end
    end

    assign bus.pos         = pos_q;
    assign bus.dir         = dir_q;
    assign bus.step_valid  = step_valid_q;
    assign bus.index_pulse = index_pulse_q;
    assign bus.vel         = vel_q;
    assign bus.vel_valid   = vel_valid_q;
    assign bus.err_illegal = err_q;
endmodule
